// File: rtl/parity_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | parity_sched_pkg : shared types and constants for parity_frame_scheduler   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package parity_sched_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int FRAME_W    = DEF_DATA_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit from the XOR-reduced payload and the requester's mode.
  function automatic logic frame_parity(input logic payload_xor, input logic mode);
    return payload_xor ^ (mode == PAR_ODD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first request at/after ptr     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int   cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/parity_frame_scheduler.sv
// +----------------------------------------------------------------------------+
// | parity_frame_scheduler : round-robin byte capture, parity framing and      |
// | LSB-first serial transmit under valid/ready.                    Rev 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module parity_frame_scheduler
  import parity_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   data,
  input  logic [NUM_REQ-1:0]          odd_sel,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        tx_bit,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        tx_last,
  output logic [$clog2(NUM_REQ)-1:0]  src_id,
  output logic                        busy
);

  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int FRAME_LEN = DATA_W + 1;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  state_e                 state_q, state_d;
  logic [FRAME_LEN-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       src_q, src_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic [DATA_W-1:0]      win_data;
  logic                   cnt_last;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign win_data = data[int'(arb_idx)*DATA_W +: DATA_W];
  assign src_id   = src_q;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    gnt      = '0;
    tx_bit   = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    busy     = 1'b0;
    cnt_last = (cnt_q == CNT_W'(DATA_W));

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          // Grant is masked while reset is held so it reads zero like every other output.
          gnt     = rst_n ? arb_gnt : '0;
          frame_d = {frame_parity(^win_data, odd_sel[arb_idx]), win_data};
          src_d   = arb_idx;
          ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = frame_q[cnt_q];
        tx_last  = cnt_last;
        if (tx_ready) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_parity_frame_scheduler : scoreboard bench with directed and random      |
// | request traffic.                                                Rev 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_parity_frame_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int FW = DW + 1;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic [N-1:0]    req      = '0;
  logic [N*DW-1:0] data     = '0;
  logic [N-1:0]    odd_sel  = '0;
  logic            tx_ready = 1'b1;
  logic [N-1:0]    gnt;
  logic            tx_bit, tx_valid, tx_last, busy;
  logic [1:0]      src_id;

  parity_frame_scheduler #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
    .odd_sel  (odd_sel),
    .gnt      (gnt),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .src_id   (src_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int             tests = 0;
  int             fails = 0;
  logic [FW-1:0]  exp_q [N][$];
  int             grant_log[$];
  int             ready_pct = 100;

  bit             m_busy = 1'b0;
  int             m_bit = 0;
  int             m_src = 0;
  int             m_ptr = 0;
  logic [FW-1:0]  m_frame = '0;
  int             cyc = 0;
  int             last_grant = -1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame = payload then one parity bit making the frame's total ones even/odd.
  function automatic logic [FW-1:0] mk_frame(input logic [DW-1:0] d, input logic odd);
    int   ones;
    logic p;
    ones = 0;
    for (int b = 0; b < DW; b++) ones += int'(d[b]);
    p = ((ones % 2) == 1) ^ odd;
    return {p, d};
  endfunction

  task automatic issue(input int i, input logic [DW-1:0] d, input logic o);
    data[i*DW +: DW] = d;
    odd_sel[i]       = o;
    req[i]           = 1'b1;
    exp_q[i].push_back(mk_frame(d, o));
  endtask

  task automatic step();
    logic [N-1:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    req      = req & ~g;
    tx_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((req != '0 || m_busy) && n < bound) begin
      step();
      n++;
    end
    chk("drain_timeout", int'(req != '0 || m_busy), 0);
  endtask

  // Monitor / scoreboard
  initial forever begin
    int w;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      m_busy     = 1'b0;
      m_ptr      = 0;
      last_grant = -1;
    end else if (m_busy) begin
      chk("gnt_during_shift", int'(gnt), 0);
      chk("tx_valid", int'(tx_valid), 1);
      chk("busy", int'(busy), 1);
      chk("tx_bit", int'(tx_bit), int'(m_frame[m_bit]));
      chk("tx_last", int'(tx_last), int'(m_bit == DW));
      chk("src_id", int'(src_id), m_src);
      if (tx_ready) begin
        if (m_bit == DW) m_busy = 1'b0;
        else m_bit++;
      end
    end else begin
      chk("idle_tx_valid", int'(tx_valid), 0);
      chk("idle_busy", int'(busy), 0);
      if (req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        chk("gnt_winner", int'(gnt), 1 << w);
        if (last_grant >= 0) chk("frame_spacing", int'((cyc - last_grant) >= DW + 2), 1);
        last_grant = cyc;
        grant_log.push_back(w);
        if (exp_q[w].size() == 0) begin
          chk("exp_frame_available", 0, 1);
          m_frame = '0;
        end else begin
          m_frame = exp_q[w].pop_front();
        end
        m_src  = w;
        m_bit  = 0;
        m_busy = 1'b1;
        m_ptr  = (w + 1) % N;
      end else begin
        chk("gnt_idle", int'(gnt), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_bit", int'(tx_bit), 0);
    chk("rst_tx_last", int'(tx_last), 0);
    chk("rst_src_id", int'(src_id), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 0xA5 even on requester 0
    issue(0, 8'hA5, 1'b0);
    drain(50);
    chk("a5_grant_src", grant_log[grant_log.size()-1], 0);

    // 0x00 odd then 0xFF even on requester 1, back to back
    issue(1, 8'h00, 1'b1);
    for (n = 0; n < 20 && req[1]; n++) step();
    issue(1, 8'hFF, 1'b0);
    drain(50);

    // 0x3C on requester 3 with a three-cycle stall at bit 4
    issue(3, 8'h3C, 1'b0);
    for (n = 0; n < 50 && !(m_busy && m_bit == 4); n++) step();
    chk("reach_bit4", int'(m_busy && m_bit == 4), 1);
    tx_ready  = 1'b0;
    ready_pct = 0;
    step();
    step();
    ready_pct = 100;
    step();
    drain(50);

    // requesters 0 and 2 held continuously
    n0 = grant_log.size();
    for (n = 0; n < 200 && grant_log.size() < n0 + 4; n++) begin
      if (!req[0]) issue(0, DW'($urandom), 1'($urandom));
      if (!req[2]) issue(2, DW'($urandom), 1'($urandom));
      step();
    end
    drain(100);
    for (int k = 0; k < 4; k++) chk("rr_0_2_order", grant_log[n0 + k], (k % 2 == 0) ? 0 : 2);

    // reset in the middle of a frame while requesters 1 and 3 wait
    issue(2, DW'($urandom), 1'($urandom));
    for (n = 0; n < 50 && !(m_busy && m_bit == 5); n++) step();
    chk("reach_bit5", int'(m_busy && m_bit == 5), 1);
    issue(1, DW'($urandom), 1'($urandom));
    issue(3, DW'($urandom), 1'($urandom));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tx_valid", int'(tx_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_tx_last", int'(tx_last), 0);
    chk("abort_tx_bit", int'(tx_bit), 0);
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_src_id", int'(src_id), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = grant_log.size();
    drain(100);
    chk("post_reset_grant", grant_log[n0], 1);
    chk("post_reset_grant2", grant_log[n0 + 1], 3);

    // all four requesters held continuously
    n0 = grant_log.size();
    for (n = 0; n < 300 && grant_log.size() < n0 + 5; n++) begin
      for (int i = 0; i < N; i++)
        if (!req[i]) issue(i, DW'($urandom), 1'($urandom));
      step();
    end
    drain(200);
    for (int k = 0; k < 5; k++) chk("rr_all_order", grant_log[n0 + k], k % N);

    // random traffic with random back-pressure
    ready_pct = 70;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 99) < 20) issue(i, DW'($urandom), 1'($urandom));
      step();
    end
    drain(3000);
    for (int i = 0; i < N; i++) chk("queue_empty", exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/parity_frame_scheduler.md
Name: parity_frame_scheduler

Overview:
Shares one parity-framing and serial-transmit path between NUM_REQ byte requesters. A round-robin arbiter picks one requester and captures its byte. The block appends an even or odd parity bit, chosen per requester, to form a DATA_W+1-bit frame. It then shifts the frame out one bit at a time under a valid/ready handshake. It sits between the byte producers and the serial link or checker downstream.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, payload width per requester

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester request; held until that requester's gnt
data  input  NUM_REQ*DATA_W  packed payloads; requester i uses bits [i*DATA_W +: DATA_W]
odd_sel  input  NUM_REQ  per-requester parity mode: 0 = even, 1 = odd
gnt  output  NUM_REQ  one-hot, single-cycle pulse; payload captured at this clock edge
tx_bit  output  1  current serial bit
tx_valid  output  1  tx_bit is valid
tx_ready  input  1  downstream accepts tx_bit on this cycle
tx_last  output  1  tx_bit is the parity bit, i.e. the last bit of the frame
src_id  output  clog2(NUM_REQ)  index of the requester that owns the current frame
busy  output  1  frame in progress

Behaviour:
- One clock domain; rst_n is asynchronous and active-low. Asserting rst_n = 0 clears all state immediately.
- Reset values: gnt = 0, tx_bit = 0, tx_valid = 0, tx_last = 0, src_id = 0, busy = 0, state = IDLE, bit counter = 0, round-robin pointer = 0.
- State machine has two states: IDLE and SHIFT.
- IDLE, req == 0: stay in IDLE; all outputs idle.
- IDLE, req != 0:
  - gnt is driven combinationally for the winner.
  - The winner is the first set req bit at or after the pointer, searching circularly.
  - On that clock edge the block captures data[winner] and odd_sel[winner] and sets src_id = winner.
  - Pointer becomes (winner + 1) mod NUM_REQ.
  - Next state is SHIFT.
- Frame format (DATA_W+1 bits, sent LSB first): bits 0..DATA_W-1 = payload, bit DATA_W = parity.
  - Even parity: parity = XOR-reduce(payload), so the total number of ones in the frame is even.
  - Odd parity: parity = inverted XOR-reduce(payload).
- SHIFT:
  - tx_valid = 1, busy = 1, tx_bit = frame[cnt].
  - tx_last = 1 when cnt == DATA_W.
  - cnt advances only on a cycle where tx_valid && tx_ready. When tx_ready = 0, tx_bit, cnt and src_id hold.
  - When the last bit is accepted, go to IDLE with cnt = 0, tx_valid = 0, busy = 0.
- Latency and throughput:
  - First bit is valid the cycle after gnt.
  - A frame takes at least DATA_W+1 SHIFT cycles.
  - At least one IDLE cycle separates frames, so the maximum rate is one frame per DATA_W+2 cycles.
- No grant is issued while in SHIFT. req edges during SHIFT are ignored until the block returns to IDLE. A requester that drops req before its grant is simply never granted.
- Simultaneous requests are resolved by round-robin only. A requester holding req continuously waits at most NUM_REQ-1 frames.
- Reset mid-frame aborts the frame: tx_valid drops asynchronously, no partial parity bit is sent, and the pointer returns to 0.
- req bits with index >= NUM_REQ do not exist. The gnt output is always one-hot or zero.

Decomposition:
- Package parity_sched_pkg holds:
  - FRAME_W = DATA_W + 1
  - state encoding constants ST_IDLE and ST_SHIFT
  - parity mode constants PAR_EVEN = 0 and PAR_ODD = 1
- Sub-module rr_arbiter (parameter N). Inputs: req, pointer. Outputs: one-hot gnt and the encoded winner index. It is purely combinational.
- The top level holds the FSM, the frame register, the counter and the pointer register.

Test Plan:
- Reset, then req0 with data 0xA5 and even mode, tx_ready = 1 -> gnt[0] pulses once; tx_bit = 1,0,1,0,0,1,0,1 then 0; tx_last on the 9th bit; src_id = 0.
- req1 with 0x00 in odd mode, then 0xFF in even mode -> parity bits 1 and 0 respectively; frame starts are at least 10 cycles apart.
- req0 and req2 held high continuously -> grant order 0, 2, 0, 2; src_id tracks each grant; gnt is never asserted during SHIFT.
- Frame 0x3C with tx_ready low for 3 cycles at bit 4 -> tx_bit = 1 and tx_valid held for 3 cycles; frame completes intact and tx_last appears once.
- Reset asserted at bit 5 while req3 is pending -> all outputs 0 asynchronously; after release the next grant goes to the lowest-index pending requester from pointer 0.
- All four req bits high, with NUM_REQ = 4 -> grant order 0, 1, 2, 3, 0; every frame's parity matches its odd_sel.
